// File: rtl/imem_pkg.sv
// imem_pkg: shared definitions for the instruction memory slice.
//   IMEM_NOP_INST  default fill / fault-response word (addi x0,x0,0)
//   imem_state_e   init sequencer states
//   imem_fault_e   fault cause encoding (debug visibility only)
//   BOOT_PROG      8-word boot program used when IMEM_BOOT_PROG_EN is defined
package imem_pkg;

    localparam logic [31:0] IMEM_NOP_INST = 32'h0000_0013;
    localparam int unsigned BOOT_WORDS    = 8;

    typedef enum logic {
        IMEM_INIT,
        IMEM_RUN
    } imem_state_e;

    typedef enum logic [1:0] {
        FAULT_NONE         = 2'd0,
        FAULT_MISALIGNED   = 2'd1,
        FAULT_OUT_OF_RANGE = 2'd2
    } imem_fault_e;

    localparam logic [31:0] BOOT_PROG [BOOT_WORDS] = '{
        32'h0094_0333, 32'h4139_03b3, 32'h035a_02b3, 32'h017b_4e33,
        32'h019c_1eb3, 32'h01bd_5f33, 32'h00d6_7fb3, 32'h00f7_68b3
    };

    // Boot image word for a given index; words past the boot program get the fill value.
    function automatic logic [31:0] boot_word(input logic [31:0] idx, input logic [31:0] fill);
        if (idx < BOOT_WORDS) begin
            return BOOT_PROG[idx[2:0]];
        end
        return fill;
    endfunction

endpackage

// File: rtl/imem_init_seq.sv
// imem_init_seq: post-reset array fill sequencer for imem_sync.
// Walks the word index 0..DEPTH_WORDS-1, one write per cycle, then parks in RUN.
// Optional macro IMEM_BOOT_PROG_EN: fill words 0..7 with the boot program instead of NOPs.
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high; restarts the fill from index 0
//   init_busy  high while the fill is in progress
//   init_we    array write strobe for the fill
//   init_idx   word index being filled
//   init_data  word value being filled
module imem_init_seq
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 8,
    parameter int unsigned IDX_W       = 3,
    parameter logic [31:0] NOP_INST    = IMEM_NOP_INST
) (
    input  logic             clk,
    input  logic             reset,
    output logic             init_busy,
    output logic             init_we,
    output logic [IDX_W-1:0] init_idx,
    output logic [31:0]      init_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    imem_state_e      state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IMEM_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_busy = 1'b0;
        init_we   = 1'b0;
        unique case (state_q)
            IMEM_INIT: begin
                init_busy = 1'b1;
                init_we   = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = IMEM_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IMEM_RUN: begin
            end
        endcase
    end

    assign init_idx = cnt_q;

`ifdef IMEM_BOOT_PROG_EN
    assign init_data = boot_word(32'(cnt_q), NOP_INST);
`else
    assign init_data = NOP_INST;
`endif

endmodule

// File: rtl/imem_sync.sv
// imem_sync: synchronous RV32 instruction memory with a one-cycle registered response.
// Optional macro IMEM_BOOT_PROG_EN (handled in imem_init_seq): boot program preload.
// Ports:
//   clk, reset             clock (rising edge), synchronous active-high reset
//   req_valid/ready/addr   fetch request channel (byte address)
//   resp_valid/ready       response channel handshake
//   resp_inst, resp_fault  fetched word (NOP on fault) and misaligned/out-of-range flag
//   wr_en/addr/data/be     program-load write port with byte enables (RUN state only)
//   init_busy              array fill in progress; requests and writes ignored
module imem_sync
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 8,
    parameter int unsigned ADDR_W      = 32,
    parameter logic [31:0] NOP_INST    = IMEM_NOP_INST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_inst,
    output logic              resp_fault,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_be,
    output logic              init_busy
);

    localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned WIDX_W = ADDR_W - 2;
    localparam logic [WIDX_W-1:0] DEPTH_LIM = WIDX_W'(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    logic             init_we;
    logic [IDX_W-1:0] init_idx;
    logic [31:0]      init_data;

    imem_init_seq #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W),
        .NOP_INST    (NOP_INST)
    ) u_init_seq (
        .clk       (clk),
        .reset     (reset),
        .init_busy (init_busy),
        .init_we   (init_we),
        .init_idx  (init_idx),
        .init_data (init_data)
    );

    logic run;
    assign run = !init_busy;

    // Fetch decode
    logic [WIDX_W-1:0] req_idx;
    imem_fault_e       req_cause;
    logic              req_fault;
    logic              accept;

    assign req_idx = req_addr[ADDR_W-1:2];

    always_comb begin
        req_cause = FAULT_NONE;
        if (req_addr[1:0] != 2'b00) begin
            req_cause = FAULT_MISALIGNED;
        end else if (req_idx >= DEPTH_LIM) begin
            req_cause = FAULT_OUT_OF_RANGE;
        end
    end

    assign req_fault = (req_cause != FAULT_NONE);
    assign req_ready = run && (!resp_valid || resp_ready);
    assign accept    = req_valid && req_ready;

    // Write decode
    logic [WIDX_W-1:0] wr_idx;
    logic              wr_ok;

    assign wr_idx = wr_addr[ADDR_W-1:2];
    assign wr_ok  = run && wr_en && (wr_addr[1:0] == 2'b00) && (wr_idx < DEPTH_LIM);

    // Array has no reset; the init sequencer rewrites every word after each reset.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_idx] <= init_data;
        end else if (wr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx[IDX_W-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Response register; reading mem here sees the pre-write word (read-before-write).
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_inst_q, resp_inst_d;
    logic        resp_fault_q, resp_fault_d;

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_inst_d  = resp_inst_q;
        resp_fault_d = resp_fault_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_fault_d = req_fault;
            if (req_fault) begin
                resp_inst_d = NOP_INST;
            end else begin
                resp_inst_d = mem[req_idx[IDX_W-1:0]];
            end
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_inst_q  <= NOP_INST;
            resp_fault_q <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_inst_q  <= resp_inst_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_inst  = resp_inst_q;
    assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_imem_sync.sv
// tb_imem_sync: self-checking bench for imem_sync (table vectors, directed corner
// sequences, randomized traffic against a word-array reference model).
module tb_imem_sync;

    localparam int DEPTH = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic        resp_fault;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        init_busy;

    imem_sync dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_inst  (resp_inst),
        .resp_fault (resp_fault),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .init_busy  (init_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    bit          m_run   = 1'b0;
    int          m_cnt   = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_inst  = NOP;
    bit          m_fault = 1'b0;

    function automatic logic [31:0] init_word(input int i);
`ifdef IMEM_BOOT_PROG_EN
        logic [31:0] boot [8];
        boot = '{32'h00940333, 32'h413903b3, 32'h035a02b3, 32'h017b4e33,
                 32'h019c1eb3, 32'h01bd5f33, 32'h00d67fb3, 32'h00f768b3};
        if (i < 8) return boot[i];
`endif
        return NOP;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: check req_ready against the model, advance model, then check outputs.
    task automatic cycle();
        bit exp_ready;
        bit acc;
        #1;
        exp_ready = m_run && (!m_valid || resp_ready);
        if (!reset) chk("req_ready", req_ready, exp_ready);
        acc = req_valid && exp_ready;
        if (reset) begin
            m_run = 0; m_cnt = 0; m_valid = 0; m_inst = NOP; m_fault = 0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = init_word(i);
        end else begin
            if (acc) begin
                m_valid = 1;
                m_fault = (req_addr % 4 != 0) || (req_addr / 4 >= DEPTH);
                m_inst  = m_fault ? NOP : m_mem[req_addr / 4];
            end else if (resp_ready) begin
                m_valid = 0;
            end
            if (m_run && wr_en && (wr_addr % 4 == 0) && (wr_addr / 4 < DEPTH)) begin
                for (int b = 0; b < 4; b++)
                    if (wr_be[b]) m_mem[wr_addr / 4][8*b +: 8] = wr_data[8*b +: 8];
            end
            if (!m_run) begin
                m_cnt++;
                if (m_cnt == DEPTH) m_run = 1;
            end
        end
        @(posedge clk);
        #1;
        chk("resp_valid", resp_valid, m_valid);
        chk("init_busy", init_busy, !m_run);
        if (m_valid || reset) begin
            chk("resp_inst", resp_inst, m_inst);
            chk("resp_fault", resp_fault, m_fault);
        end
    endtask

    task automatic idle();
        req_valid = 0; wr_en = 0; resp_ready = 1;
    endtask

    // Release reset and count cycles until init finishes.
    task automatic release_and_wait(input string name);
        int n = 0;
        reset = 0;
        while (init_busy === 1'b1 && n < 50) begin
            cycle();
            n++;
        end
        chk(name, n, DEPTH);
        chk({name, "_ready"}, req_ready, 1);
    endtask

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(0, DEPTH - 1) * 4;
        if (r == 6) return $urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3);
        if (r == 7) return $urandom_range(DEPTH, DEPTH + 7) * 4;
        return $urandom;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic        fault;
    } vec_t;

    vec_t tbl [12];

    initial begin
        for (int i = 0; i < 8; i++) tbl[i] = '{32'(i * 4), init_word(i), 1'b0};
        tbl[8]  = '{32'h0000_0002, NOP, 1'b1};
        tbl[9]  = '{32'h0000_0020, NOP, 1'b1};
        tbl[10] = '{32'h0000_001D, NOP, 1'b1};
        tbl[11] = '{32'hFFFF_FFFC, NOP, 1'b1};

        req_addr = 0; wr_addr = 0; wr_data = 0; wr_be = 0;
        idle();

        // Reset for 2 cycles, write attempt during INIT must be ignored
        reset = 1;
        cycle();
        cycle();
        chk("rst_valid", resp_valid, 0);
        chk("rst_fault", resp_fault, 0);
        chk("rst_inst", resp_inst, NOP);
        chk("rst_ready", req_ready, 0);
        chk("rst_busy", init_busy, 1);
        wr_en = 1; wr_addr = 0; wr_data = 32'hCAFE_F00D; wr_be = 4'hF;
        release_and_wait("init_cycles");
        wr_en = 0;

        // Back-to-back table fetches
        for (int i = 0; i < 12; i++) begin
            req_valid = 1; req_addr = tbl[i].addr; resp_ready = 1;
            cycle();
            chk("tbl_valid", resp_valid, 1);
            chk("tbl_inst", resp_inst, tbl[i].inst);
            chk("tbl_fault", resp_fault, tbl[i].fault);
        end
        idle();
        cycle();
        chk("drop_valid", resp_valid, 0);

        // Stall: response held stable, no accept
        req_valid = 1; req_addr = 32'h08;
        cycle();
        req_addr = 32'h0C; resp_ready = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("hold_inst", resp_inst, init_word(2));
            chk("hold_ready", req_ready, 0);
        end
        resp_ready = 1;
        cycle();
        chk("after_hold_inst", resp_inst, init_word(3));
        idle();
        cycle();

        // Same-cycle write and fetch: old word, then merged word; misaligned write dropped
        req_valid = 1; req_addr = 32'h04;
        wr_en = 1; wr_addr = 32'h04; wr_data = 32'hDEAD_BEEF; wr_be = 4'b0011;
        cycle();
        chk("rbw_old", resp_inst, init_word(1));
        wr_en = 1; wr_addr = 32'h06; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
        req_valid = 0;
        cycle();
        wr_en = 0; req_valid = 1; req_addr = 32'h04;
        cycle();
`ifdef IMEM_BOOT_PROG_EN
        chk("rbw_new", resp_inst, 32'h4139_BEEF);
`else
        chk("rbw_new", resp_inst, 32'h0000_BEEF);
`endif
        idle();
        cycle();

        // Reset while a response is stalled; written word reverts
        wr_en = 1; wr_addr = 32'h14; wr_data = 32'h1234_5678; wr_be = 4'hF;
        cycle();
        wr_en = 0; req_valid = 1; req_addr = 32'h14; resp_ready = 0;
        cycle();
        chk("pre_rst_inst", resp_inst, 32'h1234_5678);
        req_valid = 0;
        cycle();
        reset = 1;
        cycle();
        chk("rst_stall_valid", resp_valid, 0);
        resp_ready = 1;
        release_and_wait("reinit_cycles");
        req_valid = 1; req_addr = 32'h14;
        cycle();
        chk("reinit_word", resp_inst, init_word(5));
        idle();
        cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            reset      = ($urandom_range(0, 199) == 0);
            req_valid  = ($urandom_range(0, 9) < 7);
            req_addr   = rand_addr();
            resp_ready = ($urandom_range(0, 9) < 7);
            wr_en      = ($urandom_range(0, 9) < 2);
            wr_addr    = rand_addr();
            wr_data    = $urandom;
            wr_be      = 4'($urandom);
            cycle();
        end
        reset = 0;
        idle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_sync.md
Name: imem_sync

Overview:
Parametrised, synchronous instruction memory for the RV32 fetch path. It has a valid/ready fetch request channel and a registered response channel with one cycle of latency. A side write port loads programs. After every reset, a hardware init sequencer fills the whole array with NOPs, or with the boot program when that option is enabled. Misaligned and out-of-range fetches are reported as faults.

Parameters:
DEPTH_WORDS, 8, number of 32-bit words stored (8 gives 32 bytes).
ADDR_W, 32, width of byte addresses on the request and write ports.
NOP_INST, 32'h00000013, fill value and fault-response value (addi x0,x0,0).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  reset, synchronous, active-high.
req_valid  input  1  fetch request valid.
req_ready  output  1  fetch request can be accepted.
req_addr  input  ADDR_W  fetch byte address.
resp_valid  output  1  response valid.
resp_ready  input  1  consumer accepts the response.
resp_inst  output  32  instruction word, little-endian ({B[a+3],B[a+2],B[a+1],B[a]}).
resp_fault  output  1  the fetch was misaligned or out of range.
wr_en  input  1  program-load write strobe.
wr_addr  input  ADDR_W  write byte address, word-aligned.
wr_data  input  32  write data.
wr_be  input  4  byte enables; bit i writes byte lane i.
init_busy  output  1  init sequencer is active.

Behaviour:
- FSM states are INIT and RUN. Reset forces INIT with the init counter at 0.
- Reset values: resp_valid=0, resp_fault=0, resp_inst=NOP_INST, req_ready=0, init_busy=1.
- INIT state:
  - Writes one word per cycle at index = counter. The value is NOP_INST, or the boot word when the option is enabled.
  - The counter runs 0..DEPTH_WORDS-1, then the FSM goes to RUN.
  - init_busy=1 for exactly DEPTH_WORDS cycles after reset deasserts.
  - Requests and wr_en are ignored in INIT.
- req_ready = RUN && (!resp_valid || resp_ready). This is combinational and creates no dependency of req_ready on req_valid.
- Accept: req_valid && req_ready at a rising edge. On the next cycle resp_valid=1 with data for the accepted address.
- Back-to-back accepts are allowed, giving one response per cycle at full throughput.
- Hold: while resp_valid && !resp_ready, resp_inst and resp_fault stay stable and no new request is accepted.
- resp_valid drops after a handshake (resp_valid && resp_ready) when no new request is accepted in the same cycle.
- Word index = req_addr[ADDR_W-1:2].
- Fault rules:
  - Fault if req_addr[1:0]!=0, or if index >= DEPTH_WORDS.
  - On a fault: resp_fault=1 and resp_inst=NOP_INST; the array is not read.
  - On a good fetch: resp_fault=0.
- Writes:
  - Happen in RUN when wr_en=1, wr_addr is aligned and in range, with per-byte enables.
  - Misaligned or out-of-range writes are silently dropped.
- Write and fetch to the same word in the same cycle: the response returns the OLD word (read-before-write). The next fetch returns the new word.
- Reset mid-operation (including mid-INIT or while a response is stalled):
  - The pending response is dropped (resp_valid=0) and the FSM re-enters INIT.
  - The array is fully re-initialised.

Optional Feature:
Macro IMEM_BOOT_PROG_EN.
- Defined: INIT writes the boot program into words 0..7 (only as many as DEPTH_WORDS holds) and NOP_INST into the rest. Boot program: 0x00940333, 0x413903b3, 0x035a02b3, 0x017b4e33, 0x019c1eb3, 0x01bd5f33, 0x00d67fb3, 0x00f768b3.
- Undefined: every word is initialised to NOP_INST.
- Timing is identical in both builds.

Decomposition:
- Package imem_pkg holds:
  - the NOP_INST default constant;
  - the state enum {IMEM_INIT, IMEM_RUN};
  - the 8-entry boot program constant array;
  - a fault-cause encoding (MISALIGNED, OUT_OF_RANGE), for debug only.
- One sub-module, imem_init_seq: the counter and FSM. It outputs init_busy, init_we, init_idx and init_data; the top level muxes these against the write port.

Test Plan:
1. Reset for 2 cycles, then release: init_busy=1 for exactly 8 cycles; req_ready then rises. Fetch 0x00 gives resp_inst=0x00000013, resp_fault=0.
2. IMEM_BOOT_PROG_EN, resp_ready=1: back-to-back fetches 0x00..0x1C step 4 give 0x00940333, 0x413903b3, 0x035a02b3, 0x017b4e33, 0x019c1eb3, 0x01bd5f33, 0x00d67fb3, 0x00f768b3 on consecutive cycles.
3. Fetch 0x08, then hold resp_ready=0 for 3 cycles: resp_inst=0x035a02b3 stays stable and req_ready=0. Release resp_ready: one handshake, then the next request is accepted.
4. Fetch 0x02: resp_fault=1, resp_inst=0x00000013. Fetch 0x20 with DEPTH_WORDS=8: resp_fault=1.
5. Boot build: write 0x04 with data 0xDEADBEEF, be=4'b0011, in the same cycle as a fetch of 0x04. The response is 0x413903b3; a refetch gives 0x4139BEEF. A write to 0x06 is dropped.
6. Assert reset while a response is stalled: resp_valid=0 next cycle, init_busy=1 for 8 cycles, and an earlier written word returns to its init value.
